// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// A grant stays with its owner for a whole message; an idle owner loses it after HOLD_TIMEOUT cycles.
`timescale 1ns/1ps
module uart_tx_arbiter #(
   parameter int NB_DATA      = 8,
   parameter int N_REQ        = 2,
   parameter int HOLD_TIMEOUT = 1000
) (
   input  logic                     clk,
   input  logic                     i_rst,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ-1:0]         i_last,
   input  logic [N_REQ*NB_DATA-1:0] i_data,
   output logic [N_REQ-1:0]         o_ack,
   output logic [N_REQ-1:0]         o_gnt,
   output logic                     o_tx_start,
   output logic [NB_DATA-1:0]       o_tx_data,
   input  logic                     i_tx_done,
   output logic                     o_busy,
   output logic                     o_err,
   output logic [1:0]               o_state
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      HOLD      = 2'd2
   } state_t;

   // Handshake: requester k holds i_req[k] with stable i_data/i_last until o_ack[k]
   // pulses; the byte is taken on that pulse and the requester may then move on.
   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               start_q, start_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic [NB_DATA-1:0] data_arr [N_REQ];
   logic [2*N_REQ-1:0] req_rot;
   logic               win_found;
   logic [IDX_W:0]     win_sum;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   owner_next;
   logic               issue;
   logic [IDX_W-1:0]   issue_idx;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = i_data[g*NB_DATA +: NB_DATA];
   end

   // Rotate so the rr pointer sits at bit 0; the first set bit is the winner.
   assign req_rot = {i_req, i_req} >> rr_q;

   always_comb begin
      win_found = 1'b0;
      win_sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req_rot[i]) begin
            win_found = 1'b1;
            win_sum   = {1'b0, rr_q} + (IDX_W+1)'(i);
         end
      end
      if (win_sum >= (IDX_W+1)'(N_REQ)) begin
         win_sum = win_sum - (IDX_W+1)'(N_REQ);
      end
      win_idx = win_sum[IDX_W-1:0];
   end

   assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      data_d    = data_q;
      start_d   = 1'b0;
      ack_d     = '0;
      err_d     = 1'b0;
      issue     = 1'b0;
      issue_idx = owner_q;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               issue     = 1'b1;
               issue_idx = win_idx;
            end
         end
         WAIT_DONE: begin
            // A done coinciding with our own start pulse belongs to no byte of ours.
            if (i_tx_done && !start_q) begin
               if (last_q) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  rr_d    = owner_next;
               end else if (i_req[owner_q]) begin
                  issue = 1'b1;
               end else begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end
            end
         end
         HOLD: begin
            if (i_req[owner_q]) begin
               issue = 1'b1;
            end else if (cnt_q == CNT_W'(HOLD_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
               gnt_d   = '0;
               rr_d    = owner_next;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         state_d = WAIT_DONE;
         owner_d = issue_idx;
         gnt_d   = N_REQ'(1) << issue_idx;
         ack_d   = N_REQ'(1) << issue_idx;
         data_d  = data_arr[issue_idx];
         last_d  = i_last[issue_idx];
         start_d = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         gnt_q   <= '0;
         ack_q   <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         start_q <= start_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign o_ack      = ack_q;
   assign o_gnt      = gnt_q;
   assign o_tx_start = start_q;
   assign o_tx_data  = data_q;
   assign o_busy     = busy_q;
   assign o_err      = err_q;
   assign o_state    = state_q;

endmodule
